ddc_iq_downconverter: RTL and testbench

//  Digital down-converter for the radar IF chain. Mixes a real 12-bit IF sample stream with an internal NCO.
//  The NCO runs at 100 MHz clk with a 25 MHz default IF. The complex baseband product is low-pass filtered by a 16-tap FIR.

---
 rtl/ddc_iq_downconverter.sv | 166 ++++++++++++++++
 tb/tb_ddc_iq_downconverter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ddc_iq_downconverter.sv
// rtl/ddc_iq_downconverter.sv - NCO mixer plus FIR I/Q down-converter; DDC_DECIM_EN enables decimated output
module ddc_iq_downconverter #(
    parameter int                    IN_W      = 12,
    parameter int                    LUT_W     = 16,
    parameter int                    OUT_W     = 44,
    parameter int                    NUM_TAPS  = 16,
    parameter logic [31:0]           PHASE_INC = 32'h4000_0000,
    parameter logic [NUM_TAPS*16-1:0] COEFS    = {NUM_TAPS{16'sd2048}},
    parameter int                    DECIM     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  if_data_in,
    output logic signed [OUT_W-1:0] i_data_out,
    output logic signed [OUT_W-1:0] q_data_out,
    output logic                    data_out_valid
);

    localparam int  PROD_W     = IN_W + LUT_W;
    localparam int  LUT_AW     = 10;
    localparam int  LUT_SIZE   = 1 << LUT_AW;
    localparam real PI         = 3.14159265358979323846;
    localparam real AMP        = real'((1 << (LUT_W - 1)) - 1);
    localparam int  FILL_EDGES = NUM_TAPS + 2;
    localparam int  CNT_W      = $clog2(FILL_EDGES + 1);

    // Quadrature lookup tables, computed at elaboration; peak is +/-AMP so -2^(LUT_W-1) never occurs
    logic signed [LUT_W-1:0] cos_tab [LUT_SIZE];
    logic signed [LUT_W-1:0] sin_tab [LUT_SIZE];

    for (genvar a = 0; a < LUT_SIZE; a++) begin : g_lut
        localparam real ANG = 2.0 * PI * real'(a) / real'(LUT_SIZE);
        localparam real CV  = AMP * $cos(ANG);
        localparam real SV  = AMP * $sin(ANG);
        localparam int  CI  = (CV >= 0.0) ? $rtoi(CV + 0.5) : -$rtoi(0.5 - CV);
        localparam int  SI  = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(0.5 - SV);
        assign cos_tab[a] = CI[LUT_W-1:0];
        assign sin_tab[a] = SI[LUT_W-1:0];
    end

    logic        [31:0]       phase_acc;
    logic signed [IN_W-1:0]   x_r;
    logic signed [LUT_W-1:0]  cos_r;
    logic signed [LUT_W-1:0]  sin_r;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] cos_ext;
    logic signed [PROD_W-1:0] sin_ext;
    logic signed [PROD_W-1:0] mi;
    logic signed [PROD_W-1:0] mq;
    logic signed [PROD_W-1:0] tap_i [NUM_TAPS];
    logic signed [PROD_W-1:0] tap_q [NUM_TAPS];
    logic signed [OUT_W-1:0]  acc_i;
    logic signed [OUT_W-1:0]  acc_q;
    logic signed [OUT_W-1:0]  ti;
    logic signed [OUT_W-1:0]  tq;
    logic signed [OUT_W-1:0]  cf;
    logic        [CNT_W-1:0]  fill_cnt;
    logic                     filled;
    logic                     pulse;
    logic                     upd;

    assign x_ext   = {{(PROD_W - IN_W){x_r[IN_W-1]}}, x_r};
    assign cos_ext = {{(PROD_W - LUT_W){cos_r[LUT_W-1]}}, cos_r};
    assign sin_ext = {{(PROD_W - LUT_W){sin_r[LUT_W-1]}}, sin_r};

    // NCO phase accumulation, input/LUT capture and complex mixing
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc <= '0;
            x_r       <= '0;
            cos_r     <= '0;
            sin_r     <= '0;
            mi        <= '0;
            mq        <= '0;
        end else begin
            phase_acc <= phase_acc + PHASE_INC;
            x_r       <= if_data_in;
            cos_r     <= cos_tab[phase_acc[31 -: LUT_AW]];
            sin_r     <= sin_tab[phase_acc[31 -: LUT_AW]];
            mi        <= x_ext * cos_ext;
            mq        <= -(x_ext * sin_ext);
        end
    end

    // FIR delay line, newest product enters at tap 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_TAPS; n++) begin
                tap_i[n] <= '0;
                tap_q[n] <= '0;
            end
        end else begin
            tap_i[0] <= mi;
            tap_q[0] <= mq;
            for (int n = 1; n < NUM_TAPS; n++) begin
                tap_i[n] <= tap_i[n-1];
                tap_q[n] <= tap_q[n-1];
            end
        end
    end

    // Full-precision multiply-accumulate over all taps; sums wrap at OUT_W bits
    always_comb begin
        acc_i = '0;
        acc_q = '0;
        ti    = '0;
        tq    = '0;
        cf    = '0;
        for (int n = 0; n < NUM_TAPS; n++) begin
            ti    = {{(OUT_W - PROD_W){tap_i[n][PROD_W-1]}}, tap_i[n]};
            tq    = {{(OUT_W - PROD_W){tap_q[n][PROD_W-1]}}, tap_q[n]};
            cf    = {{(OUT_W - 16){COEFS[n*16+15]}}, COEFS[n*16 +: 16]};
            acc_i = acc_i + ti * cf;
            acc_q = acc_q + tq * cf;
        end
    end

    // Count edges since reset release until the delay line holds only real samples
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
        end else if (!filled) begin
            fill_cnt <= fill_cnt + CNT_W'(1);
        end
    end

    assign filled = (fill_cnt == CNT_W'(FILL_EDGES));

`ifdef DDC_DECIM_EN
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DCNT_W-1:0] dec_cnt;

    // Decimation phase counter, started by the first settled output
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (filled) begin
            dec_cnt <= (dec_cnt == DCNT_W'(DECIM - 1)) ? '0 : dec_cnt + DCNT_W'(1);
        end
    end

    assign pulse = filled && (dec_cnt == '0);
    assign upd   = !filled || pulse;
`else
    // DECIM has no effect at full rate
    assign pulse = filled && (DECIM >= 1);
    assign upd   = 1'b1;
`endif

    // Output register; before fill the outputs track the partially filled filter
    always_ff @(posedge clk) begin
        if (rst) begin
            i_data_out     <= '0;
            q_data_out     <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= pulse;
            if (upd) begin
                i_data_out <= acc_i;
                q_data_out <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_ddc_iq_downconverter.sv
// tb/tb_ddc_iq_downconverter.sv - self-checking bench for ddc_iq_downconverter against an arithmetic model
module tb_ddc_iq_downconverter;

    localparam int  NT    = 16;
    localparam int  OW    = 44;
    localparam int  FILL  = NT + 3;
    localparam int  DECIM = 4;
    localparam real PI    = 3.14159265358979323846;
    localparam logic [NT*16-1:0] COEFS_B = {{((NT - 1) * 16){1'b0}}, 16'sd1};
`ifdef DDC_DECIM_EN
    localparam bit  DEC_ON = 1'b1;
`else
    localparam bit  DEC_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [11:0]   x_a, x_b, x_c;
    logic signed [OW-1:0] oi [3];
    logic signed [OW-1:0] oq [3];
    logic                 ov [3];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          e        = 0;
    int          xs [3][0:4095];
    longint      cf [3][NT];
    logic [31:0] inc [3];
    longint      exp_i [3];
    longint      exp_q [3];

    always #5 clk = ~clk;

    ddc_iq_downconverter dut_a (
        .clk(clk), .rst(rst), .if_data_in(x_a),
        .i_data_out(oi[0]), .q_data_out(oq[0]), .data_out_valid(ov[0])
    );

    ddc_iq_downconverter #(.COEFS(COEFS_B)) dut_b (
        .clk(clk), .rst(rst), .if_data_in(x_b),
        .i_data_out(oi[1]), .q_data_out(oq[1]), .data_out_valid(ov[1])
    );

    ddc_iq_downconverter #(.PHASE_INC(32'h0)) dut_c (
        .clk(clk), .rst(rst), .if_data_in(x_c),
        .i_data_out(oi[2]), .q_data_out(oq[2]), .data_out_valid(ov[2])
    );

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, e, obs, expv);
        end
    endtask

    function automatic longint lut_val(input logic [31:0] ph, input bit want_sin);
        real ang;
        real v;
        ang = 2.0 * PI * real'(ph[31:22]) / 1024.0;
        v   = 32767.0 * (want_sin ? $sin(ang) : $cos(ang));
        return longint'($rtoi($floor(v + 0.5)));
    endfunction

    // Output expected at post-release edge ee: sample n (captured at edge n, NCO phase (n-1)*inc)
    // appears at tap j on edge n+3+j; the result is reduced to OW-bit two's complement
    function automatic void model(input int d, input int ee, output longint ei, output longint eq);
        longint              si;
        longint              sq;
        logic signed [OW-1:0] t;
        si = 0;
        sq = 0;
        for (int j = 0; j < NT; j++) begin
            int n;
            n = ee - 3 - j;
            if (n >= 1) begin
                logic [31:0] ph;
                longint      p;
                ph = inc[d] * 32'(n - 1);
                p  = longint'(xs[d][n]);
                si = si + p * lut_val(ph, 1'b0) * cf[d][j];
                sq = sq - p * lut_val(ph, 1'b1) * cf[d][j];
            end
        end
        t  = si[OW-1:0];
        ei = longint'(t);
        t  = sq[OW-1:0];
        eq = longint'(t);
    endfunction

    // One clock: record the captured samples, update the model, compare every instance
    task automatic step();
        bit     rst_now;
        bit     v_exp;
        longint mi_v;
        longint mq_v;
        rst_now = rst;
        @(posedge clk);
        #1;
        if (rst_now) begin
            e = 0;
        end else begin
            e++;
            xs[0][e] = int'(x_a);
            xs[1][e] = int'(x_b);
            xs[2][e] = int'(x_c);
        end
        v_exp = (e >= FILL) && (!DEC_ON || ((e - FILL) % DECIM == 0));
        for (int d = 0; d < 3; d++) begin
            if (e == 0) begin
                exp_i[d] = 0;
                exp_q[d] = 0;
            end else if (!DEC_ON || e < FILL || v_exp) begin
                model(d, e, mi_v, mq_v);
                exp_i[d] = mi_v;
                exp_q[d] = mq_v;
            end
            chk($sformatf("dut%0d_i", d), longint'(oi[d]), exp_i[d]);
            chk($sformatf("dut%0d_q", d), longint'(oq[d]), exp_q[d]);
            chk($sformatf("dut%0d_valid", d), longint'(ov[d]), longint'(v_exp));
        end
        x_a = 12'($urandom);
        if (rst) begin
            x_b = 12'($urandom);
            x_c = 12'($urandom);
        end
    endtask

    // Fixed-value checks taken directly from the expected waveforms
    task automatic directed();
        longint tab_i [4];
        longint tab_q [4];
        tab_i = '{32767000, 0, -32767000, 0};
        tab_q = '{0, -32767000, 0, 32767000};
        if (e >= 4 && e <= 11) begin
            chk("tap0_tone_i", longint'(oi[1]), tab_i[(e - 4) % 4]);
            chk("tap0_tone_q", longint'(oq[1]), tab_q[(e - 4) % 4]);
        end
        if (e == FILL || e == FILL + 8) begin
            chk("dc_boxcar_i", longint'(oi[2]), 64'sd107370905600);
            chk("dc_boxcar_q", longint'(oq[2]), 0);
        end
        if (e == FILL - 1) chk("valid_before_fill", longint'(ov[0]), 0);
        if (e == FILL)     chk("valid_at_fill", longint'(ov[0]), 1);
        if (e == FILL + DECIM - 1) chk("valid_mid_decim", longint'(ov[0]), DEC_ON ? 0 : 1);
        if (e == FILL + DECIM)     chk("valid_next_pulse", longint'(ov[0]), 1);
    endtask

    initial begin
        inc[0] = 32'h4000_0000;
        inc[1] = 32'h4000_0000;
        inc[2] = 32'h0;
        for (int j = 0; j < NT; j++) begin
            cf[0][j] = 2048;
            cf[1][j] = (j == 0) ? 1 : 0;
            cf[2][j] = 2048;
        end
        x_a = 12'($urandom);
        x_b = 12'($urandom);
        x_c = 12'($urandom);

        // Reset held for five clocks with random input
        rst = 1'b1;
        for (int k = 0; k < 5; k++) step();

        // Release; constant inputs on the tone and DC instances, random on the default one
        rst = 1'b0;
        x_b = 12'sd1000;
        x_c = 12'sd100;
        for (int k = 0; k < 500; k++) begin
            step();
            directed();
        end

        // Reset mid-stream for one clock
        rst = 1'b1;
        step();
        chk("midrst_i", longint'(oi[0]), 0);
        chk("midrst_q", longint'(oq[0]), 0);
        chk("midrst_valid", longint'(ov[0]), 0);

        // Fresh start must repeat the post-reset behaviour
        rst = 1'b0;
        x_b = 12'sd1000;
        x_c = 12'sd100;
        for (int k = 0; k < 1000; k++) begin
            step();
            directed();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
